// File: rtl/pif_efb_i2c_responder.sv
//------------------------------------------------------------------------------
// pif_efb_i2c_responder
// Wishbone slave standing in for the EFB primary-I2C registers (CMDR/TXDR/SR/RXDR),
// with host-side byte FIFOs in place of the I2C pins.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pif_efb_i2c_responder #(
  parameter int ACK_WAIT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic       bus_busy_i,
  input  logic       slave_tx_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  input  logic       tx_nak_i
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  WAIT_LAST = 3'((ACK_WAIT > 0) ? ACK_WAIT - 1 : 0);
  localparam logic [7:0]  ADR_CMDR  = 8'h41;
  localparam logic [7:0]  ADR_TXDR  = 8'h44;
  localparam logic [7:0]  ADR_SR    = 8'h45;
  localparam logic [7:0]  ADR_RXDR  = 8'h47;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  adr_q, adr_d, wdat_q, wdat_d, dat_q, dat_d, cmdr_q, cmdr_d;
  logic        we_q, we_d, rarc_q, rarc_d, troe_q, troe_d, busy_q, busy_d;
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  rx_mem_d [FIFO_DEPTH];
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d, tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  logic       stb, access, acc_we, rd_rx, wr_tx, rd_sr;
  logic       rx_full, rx_nempty, tx_full, tx_nempty;
  logic       rx_push, rx_ovf, tx_pop, tx_push, tx_ovf;
  logic [7:0] acc_adr, acc_dat, sr;

  assign stb       = wb_cyc_i & wb_stb_i;
  assign rx_full   = (rx_cnt_q == FULL_CNT);
  assign rx_nempty = (rx_cnt_q != '0);
  assign tx_full   = (tx_cnt_q == FULL_CNT);
  assign tx_nempty = (tx_cnt_q != '0);

  assign wb_ack_o   = (state_q == S_ACK);
  assign wb_dat_o   = dat_q;
  assign rx_ready_o = ~rx_full;
  assign tx_valid_o = tx_nempty;
  assign tx_data_o  = tx_nempty ? tx_mem_q[tx_rd_q] : 8'h00;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    dat_d    = dat_q;
    cmdr_d   = cmdr_q;
    rarc_d   = rarc_q;
    troe_d   = troe_q;
    busy_d   = bus_busy_i;
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    rx_rd_d  = rx_rd_q;
    rx_wr_d  = rx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_wr_d  = tx_wr_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    access   = 1'b0;
    acc_adr  = adr_q;
    acc_we   = we_q;
    acc_dat  = wdat_q;

    // The access commits on the edge that enters S_ACK, so the ack cycle
    // already presents the read data and the effects of the access.
    case (state_q)
      S_IDLE: begin
        if (stb) begin
          adr_d  = wb_adr_i;
          we_d   = wb_we_i;
          wdat_d = wb_dat_i;
          cnt_d  = 3'd0;
          if (ACK_WAIT == 0) begin
            access  = 1'b1;
            acc_adr = wb_adr_i;
            acc_we  = wb_we_i;
            acc_dat = wb_dat_i;
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stb) begin
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          access  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_rx   = access & ~acc_we & (acc_adr == ADR_RXDR) & rx_nempty;
    rd_sr   = access & ~acc_we & (acc_adr == ADR_SR);
    wr_tx   = access & acc_we & (acc_adr == ADR_TXDR);
    tx_pop  = tx_nempty & tx_ready_i;
    tx_push = wr_tx & (~tx_full | tx_pop);
    tx_ovf  = wr_tx & tx_full & ~tx_pop;
    rx_push = rx_valid_i & (~rx_full | rd_rx);
    rx_ovf  = rx_valid_i & rx_full & ~rd_rx;
    sr      = {tx_nempty, bus_busy_i, rarc_q, slave_tx_i, 1'b0,
               (slave_tx_i ? ~tx_full : rx_nempty), troe_q, 1'b0};

    if (access && !acc_we) begin
      case (acc_adr)
        ADR_CMDR: dat_d = cmdr_q;
        ADR_SR:   dat_d = sr;
        ADR_RXDR: dat_d = rx_nempty ? rx_mem_q[rx_rd_q] : 8'h00;
        default:  dat_d = 8'h00;
      endcase
    end
    if (access && acc_we && (acc_adr == ADR_CMDR)) cmdr_d = acc_dat;

    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_data_i;
      rx_wr_d           = rx_wr_q + 1'b1;
    end
    if (rd_rx) rx_rd_d = rx_rd_q + 1'b1;
    case ({rx_push, rd_rx})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    if (tx_push) begin
      tx_mem_d[tx_wr_q] = acc_dat;
      tx_wr_d           = tx_wr_q + 1'b1;
    end
    if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    // Sticky flags: a set in the same cycle as a clear takes priority.
    if (tx_nak_i)                             rarc_d = 1'b1;
    else if (wr_tx || (busy_q && !bus_busy_i)) rarc_d = 1'b0;
    if (rx_ovf || tx_ovf) troe_d = 1'b1;
    else if (rd_sr)       troe_d = 1'b0;
  end

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      adr_q    <= 8'h00;
      we_q     <= 1'b0;
      wdat_q   <= 8'h00;
      dat_q    <= 8'h00;
      cmdr_q   <= 8'h00;
      rarc_q   <= 1'b0;
      troe_q   <= 1'b0;
      busy_q   <= 1'b0;
      rx_mem_q <= '{default: 8'h00};
      tx_mem_q <= '{default: 8'h00};
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      dat_q    <= dat_d;
      cmdr_q   <= cmdr_d;
      rarc_q   <= rarc_d;
      troe_q   <= troe_d;
      busy_q   <= busy_d;
      rx_mem_q <= rx_mem_d;
      tx_mem_q <= tx_mem_d;
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_wr_q  <= tx_wr_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pif_efb_i2c_responder.sv
//------------------------------------------------------------------------------
// tb_pif_efb_i2c_responder
// Directed plus randomized checks against a queue-based register/FIFO model.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pif_efb_i2c_responder;

  localparam int ACK_WAIT = 1;
  localparam int DEPTH    = 4;

  logic       xclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [7:0] wb_adr_i = 8'h00, wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       bus_busy_i = 1'b0, slave_tx_i = 1'b0;
  logic       rx_valid_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_ready_o, tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i = 1'b0, tx_nak_i = 1'b0;

  pif_efb_i2c_responder #(.ACK_WAIT(ACK_WAIT), .FIFO_DEPTH(DEPTH)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .bus_busy_i(bus_busy_i), .slave_tx_i(slave_tx_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .tx_nak_i(tx_nak_i)
  );

  always #5 xclk = ~xclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] m_cmdr = 8'h00;
  logic       m_rarc = 1'b0;
  logic       m_troe = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_sr();
    logic trrdy;
    trrdy = slave_tx_i ? (tx_q.size() < DEPTH) : (rx_q.size() != 0);
    return {(tx_q.size() != 0), bus_busy_i, m_rarc, slave_tx_i, 1'b0, trrdy, m_troe, 1'b0};
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_cmdr = 8'h00;
    m_rarc = 1'b0;
    m_troe = 1'b0;
  endtask

  // One Wishbone access; the model is updated from the register-map rules.
  task automatic bus(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                     output logic [7:0] rd);
    logic [7:0] exp;
    int lat;
    @(negedge xclk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    exp = 8'h00;
    if (we) begin
      if (adr == 8'h41) m_cmdr = dat;
      if (adr == 8'h44) begin
        m_rarc = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(dat);
        else m_troe = 1'b1;
      end
    end else begin
      case (adr)
        8'h41: exp = m_cmdr;
        8'h45: begin exp = model_sr(); m_troe = 1'b0; end
        8'h47: if (rx_q.size() != 0) exp = rx_q.pop_front();
        default: exp = 8'h00;
      endcase
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge xclk); #1;
      if (wb_ack_o) begin lat = i + 1; break; end
    end
    check($sformatf("ack_latency_%s_%02h", we ? "wr" : "rd", adr), lat, ACK_WAIT + 1);
    rd = wb_dat_o;
    if (!we) check($sformatf("rdata_%02h", adr), rd, exp);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge xclk); #1;
    check("ack_single_cycle", wb_ack_o, 1'b0);
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge xclk);
    check("rx_ready", rx_ready_o, rx_q.size() < DEPTH);
    rx_valid_i = 1'b1; rx_data_i = b;
    @(posedge xclk); #1;
    rx_valid_i = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_troe = 1'b1;
  endtask

  task automatic host_pop();
    @(negedge xclk);
    check("tx_valid", tx_valid_o, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", tx_data_o, tx_q[0]);
    tx_ready_i = 1'b1;
    @(posedge xclk); #1;
    tx_ready_i = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic host_nak();
    @(negedge xclk);
    tx_nak_i = 1'b1;
    @(posedge xclk); #1;
    tx_nak_i = 1'b0;
    m_rarc = 1'b1;
  endtask

  task automatic set_busy(input logic v);
    @(negedge xclk);
    if (bus_busy_i && !v) m_rarc = 1'b0;
    bus_busy_i = v;
    @(posedge xclk); #1;
  endtask

  task automatic set_srw(input logic v);
    @(negedge xclk);
    slave_tx_i = v;
  endtask

  function automatic logic [7:0] pick_adr();
    case ($urandom_range(0, 4))
      0: return 8'h41;
      1: return 8'h44;
      2: return 8'h45;
      3: return 8'h47;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] rd;
    int seen;

    repeat (3) @(posedge xclk);
    #1;
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    sys_rst = 1'b0;
    model_reset();

    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_after_reset", rd, 8'h00);
    bus(1'b1, 8'h41, 8'h04, rd);
    bus(1'b0, 8'h41, 8'h00, rd);
    check("cmdr_readback", rd, 8'h04);
    bus(1'b0, 8'h60, 8'h00, rd);
    check("unmapped_read", rd, 8'h00);

    set_busy(1'b1);
    host_push(8'hA5);
    host_push(8'h3C);
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_busy_trrdy", rd, 8'h44);
    bus(1'b0, 8'h47, 8'h00, rd);
    check("rxdr_first", rd, 8'hA5);
    bus(1'b0, 8'h47, 8'h00, rd);
    check("rxdr_second", rd, 8'h3C);
    bus(1'b0, 8'h47, 8'h00, rd);
    check("rxdr_empty", rd, 8'h00);

    for (int i = 0; i < 5; i++) host_push(8'(8'h10 + i));
    check("rx_ready_full", rx_ready_o, 1'b0);
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_troe_set", rd[1], 1'b1);
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_troe_cleared", rd[1], 1'b0);
    for (int i = 0; i < 4; i++) bus(1'b0, 8'h47, 8'h00, rd);
    check("rx_last_kept", rd, 8'h13);

    set_busy(1'b0);
    set_srw(1'b1);
    bus(1'b1, 8'h44, 8'h11, rd);
    #1;
    check("tx_valid_after_write", tx_valid_o, 1'b1);
    check("tx_data_after_write", tx_data_o, 8'h11);
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_tip_srw", rd, 8'h94);
    host_pop();
    host_nak();
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_rarc_set", rd[5], 1'b1);
    bus(1'b1, 8'h44, 8'h22, rd);
    bus(1'b0, 8'h45, 8'h00, rd);
    check("sr_rarc_cleared", rd[5], 1'b0);
    host_pop();

    // Strobe withdrawn while waiting: nothing may happen.
    set_srw(1'b0);
    host_push(8'h77);
    @(negedge xclk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h47;
    @(posedge xclk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen = 0;
    repeat (5) begin @(posedge xclk); #1; if (wb_ack_o) seen++; end
    check("abort_no_ack", seen, 0);
    bus(1'b0, 8'h47, 8'h00, rd);
    check("abort_no_pop", rd, 8'h77);

    // Reset while waiting.
    bus(1'b1, 8'h44, 8'h55, rd);
    host_push(8'h12);
    @(negedge xclk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h41;
    @(posedge xclk); #1;
    sys_rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge xclk); #1;
    check("rst_wait_ack", wb_ack_o, 1'b0);
    check("rst_wait_tx_valid", tx_valid_o, 1'b0);
    check("rst_wait_dat", wb_dat_o, 8'h00);
    sys_rst = 1'b0;
    model_reset();
    bus(1'b0, 8'h47, 8'h00, rd);
    bus(1'b0, 8'h41, 8'h00, rd);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0: host_push(8'($urandom_range(0, 255)));
        1: host_pop();
        2: host_nak();
        3: set_busy(1'($urandom_range(0, 1)));
        4: set_srw(1'($urandom_range(0, 1)));
        5: bus(1'b0, pick_adr(), 8'h00, rd);
        6: bus(1'b1, pick_adr(), 8'($urandom_range(0, 255)), rd);
        default: bus(1'b1, 8'h44, 8'($urandom_range(0, 255)), rd);
      endcase
    end
    bus(1'b0, 8'h45, 8'h00, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pif_efb_i2c_responder.md
Name: pif_efb_i2c_responder

Overview:
- Synthesizable Wishbone slave emulating the EFB primary-I2C register subset: CMDR, TXDR, SR, RXDR.
- Answers the existing Wishbone/I2C master state machine in place of the hard EFB, for simulation and non-EFB targets.
- Host-side byte streams replace the physical I2C pins: an RX FIFO carries bytes written by the host, and a TX FIFO carries bytes returned to the host.

Parameters:
- ACK_WAIT, 1: idle cycles between accepted strobe and ack pulse (0..7).
- FIFO_DEPTH, 4: entries per RX and TX FIFO; power of 2, 2..16.

Ports:
- xclk  in  1  single clock.
- sys_rst  in  1  synchronous active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  8  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid in the ack cycle.
- wb_ack_o  out  1  single-cycle ack.
- bus_busy_i  in  1  host I2C transaction active.
- slave_tx_i  in  1  host is reading (SRW).
- rx_valid_i  in  1  host byte offered.
- rx_data_i  in  8  host byte.
- rx_ready_o  out  1  RX FIFO not full.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_data_o  out  8  TX FIFO head.
- tx_ready_i  in  1  host consumes head.
- tx_nak_i  in  1  one-cycle pulse: host NAKed the last TX byte.

Behaviour:
- Reset: all outputs 0, FIFOs empty, CMDR = 0x00, RARC/TROE cleared, FSM in IDLE. Reset mid-transfer aborts it and produces no ack.
- Access FSM states:
  - IDLE: on cyc&stb, latch adr/we/dat. Go to WAIT if ACK_WAIT>0, otherwise ACK.
  - WAIT: count ACK_WAIT cycles, then go to ACK.
  - ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
- Latency: ack arrives ACK_WAIT+1 cycles after the strobe is first sampled. With ACK_WAIT=1, strobe at cycle N gives ack at N+2.
- A strobe still high in the cycle after ack starts a new access (back-to-back is legal). Dropping cyc/stb in WAIT aborts the access: no ack, no side effects.
- Side effects (push, pop, flag clear, register write) occur once, in the ACK cycle only.
- Register map, writes:
  - 0x41 CMDR: R/W, all 8 bits stored.
  - 0x44 TXDR: write pushes wb_dat_i into the TX FIFO and clears RARC. If the FIFO is full, the byte is dropped and TROE is set.
  - 0x45 SR: writes ignored.
  - 0x47 RXDR: writes ignored.
- Register map, reads:
  - 0x41 CMDR: reads back stored value.
  - 0x44 TXDR: reads 0x00.
  - 0x45 SR: returns the status byte, then clears TROE.
  - 0x47 RXDR: pops the RX head. If the FIFO is empty, returns 0x00 with no pop.
- Any other address: read 0x00, write ignored, still acked.
- wb_dat_o holds its value until the next ack.
- SR bits, sampled in the ACK cycle:
  - [7] TIP = tx_valid_o.
  - [6] BUSY = bus_busy_i.
  - [5] RARC = sticky NAK flag.
  - [4] SRW = slave_tx_i.
  - [3] = 0.
  - [2] TRRDY = SRW ? TX not full : RX not empty.
  - [1] TROE = sticky overrun flag.
  - [0] = 0.
- RARC: set by tx_nak_i. Cleared by a TXDR write or a bus_busy_i falling edge. If set and clear coincide, set wins.
- TROE: set on an RX push attempt while full (byte dropped) or a TXDR write while full. If set and an SR-read clear coincide, set wins.
- FIFOs: log2(FIFO_DEPTH)-bit pointers wrap modulo depth, with an occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop: occupancy unchanged. When full, push is accepted only because pop frees the slot; when empty, pop is ignored and push proceeds.
  - rx_ready_o = !RX full.
  - TX pops on tx_valid_o & tx_ready_i. tx_data_o is the combinational head.

Test Plan:
- Reset, then read SR with slave_tx_i=0 and bus_busy_i=0 -> ack 2 cycles after strobe (ACK_WAIT=1); wb_dat_o=0x00.
- Write CMDR=0x04, read CMDR -> 0x04. Read address 0x60 -> 0x00, acked.
- Host pushes 0xA5, 0x3C; SR read -> 0x44 (BUSY=1, TRRDY=1 with bus_busy_i=1). RXDR reads -> 0xA5, then 0x3C, then 0x00.
- Push 5 bytes with FIFO_DEPTH=4 -> rx_ready_o=0 after the 4th; the 5th is dropped. SR bit1=1, next SR read bit1=0.
- slave_tx_i=1: write TXDR 0x11 -> tx_valid_o=1, tx_data_o=0x11, SR=0x94 (TIP, SRW, TRRDY). tx_ready_i pops it; tx_nak_i pulse -> SR bit5=1; next TXDR write clears it.
- Drop stb during WAIT -> no ack, no pop. Assert sys_rst in WAIT -> no ack, FIFOs empty, outputs 0.
